// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared encodings for the inter-stage pipeline registers.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   localparam int unsigned IDEX_CTRL_W  = 11;
   localparam int unsigned IDEX_DATA_W  = 134;
   localparam int unsigned STAGE_CTRL_W = 9;

   // Bit offsets within the ID/EX control word (LSB first)
   localparam int unsigned CTRL_ALUSRC_BIT   = 0;
   localparam int unsigned CTRL_ALUOP_LSB    = 1;
   localparam int unsigned CTRL_ALUOP_W      = 3;
   localparam int unsigned CTRL_MEMWRT_BIT   = 4;
   localparam int unsigned CTRL_MEMRD_BIT    = 5;
   localparam int unsigned CTRL_MEMTOREG_BIT = 6;
   localparam int unsigned CTRL_JUMP_BIT     = 7;
   localparam int unsigned CTRL_BTYPE_BIT    = 8;
   localparam int unsigned CTRL_BRANCH_BIT   = 9;
   localparam int unsigned CTRL_REGWRT_BIT   = 10;

   localparam logic [2:0] ALUOP_NOP = 3'b011;

   typedef struct packed {
      logic       regwrt;
      logic       branch;
      logic       btype;
      logic       jump;
      logic       memtoreg;
      logic       memrd;
      logic       memwrt;
      logic [2:0] aluop;
      logic       alusrc;
   } idex_ctrl_t;

   localparam idex_ctrl_t IDEX_CTRL_NOP = '{
      regwrt:   1'b0,
      branch:   1'b0,
      btype:    1'b0,
      jump:     1'b0,
      memtoreg: 1'b0,
      memrd:    1'b0,
      memwrt:   1'b0,
      aluop:    ALUOP_NOP,
      alusrc:   1'b0
   };

   // Later stages carry only enables, so their bubbles are all-zero
   localparam logic [0:0] IFID_CTRL_NOP  = 1'b0;
   localparam logic [3:0] EXMEM_CTRL_NOP = 4'b0000;
   localparam logic [1:0] MEMWB_CTRL_NOP = 2'b00;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } stage_state_e;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg_if
//  Description : valid/ready beat bus carrying a control word and a data word.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if
   import pipe_pkg::*;
#(
   parameter int unsigned CTRL_W = STAGE_CTRL_W,
   parameter int unsigned DATA_W = IDEX_DATA_W
);
   logic              valid;
   logic              ready;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] data;

   modport master (output valid, output ctrl, output data, input  ready);
   modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_entry_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_entry_reg
//  Description : One {valid, ctrl, data} holding entry; clear forces the NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_entry_reg
   import pipe_pkg::*;
#(
   parameter int unsigned       CTRL_W   = STAGE_CTRL_W,
   parameter int unsigned       DATA_W   = IDEX_DATA_W,
   parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              i_clr,
   input  wire logic              i_load,
   input  wire logic [CTRL_W-1:0] i_ctrl,
   input  wire logic [DATA_W-1:0] i_data,
   output logic                   o_valid,
   output logic [CTRL_W-1:0]      o_ctrl,
   output logic [DATA_W-1:0]      o_data
);
   logic              r_valid;
   logic [CTRL_W-1:0] r_ctrl;
   logic [DATA_W-1:0] r_data;

   // Data is left untouched on clear so an idle stage still shows its last word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_ctrl  <= CTRL_NOP;
         r_data  <= '0;
      end else if (i_clr) begin
         r_valid <= 1'b0;
         r_ctrl  <= CTRL_NOP;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_ctrl  <= i_ctrl;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_ctrl  = r_ctrl;
   assign o_data  = r_data;
endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Inter-stage pipeline register with handshake, flush and skid.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned       CTRL_W   = STAGE_CTRL_W,
   parameter int unsigned       DATA_W   = IDEX_DATA_W,
   parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(IDEX_CTRL_NOP),
   parameter bit                SKID     = 1'b1
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   pipe_stage_reg_if.slave   i_in,
   pipe_stage_reg_if.master  o_out,
   input  wire logic         i_flush,
   output logic [1:0]        o_occupancy
);
   logic              w_in_ready;
   logic              w_accept;
   logic              w_emit;
   logic              w_main_clr;
   logic              w_main_load;
   logic              w_main_valid;
   logic [CTRL_W-1:0] w_main_ctrl_d;
   logic [CTRL_W-1:0] w_main_ctrl_q;
   logic [DATA_W-1:0] w_main_data_d;
   logic [DATA_W-1:0] w_main_data_q;

   assign w_accept = i_in.valid & w_in_ready;
   assign w_emit   = w_main_valid & o_out.ready;

   assign i_in.ready  = w_in_ready;
   assign o_out.valid = w_main_valid;
   assign o_out.ctrl  = w_main_ctrl_q;
   assign o_out.data  = w_main_data_q;

   pipe_entry_reg #(
      .CTRL_W   (CTRL_W),
      .DATA_W   (DATA_W),
      .CTRL_NOP (CTRL_NOP)
   ) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (w_main_clr),
      .i_load  (w_main_load),
      .i_ctrl  (w_main_ctrl_d),
      .i_data  (w_main_data_d),
      .o_valid (w_main_valid),
      .o_ctrl  (w_main_ctrl_q),
      .o_data  (w_main_data_q)
   );

   if (SKID) begin : g_skid
      localparam logic [1:0] ST_EMPTY = 2'(EMPTY);
      localparam logic [1:0] ST_ONE   = 2'(ONE);
      localparam logic [1:0] ST_TWO   = 2'(TWO);

      logic [1:0]        r_state;
      logic [1:0]        w_state_nxt;
      logic              r_in_ready;
      logic              w_skid_load;
      logic              w_skid_clr;
      logic              w_skid_valid;
      logic [CTRL_W-1:0] w_skid_ctrl;
      logic [DATA_W-1:0] w_skid_data;

      pipe_entry_reg #(
         .CTRL_W   (CTRL_W),
         .DATA_W   (DATA_W),
         .CTRL_NOP (CTRL_NOP)
      ) u_skid (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_clr   (w_skid_clr),
         .i_load  (w_skid_load),
         .i_ctrl  (i_in.ctrl),
         .i_data  (i_in.data),
         .o_valid (w_skid_valid),
         .o_ctrl  (w_skid_ctrl),
         .o_data  (w_skid_data)
      );

      // The skid only holds a beat in TWO, where main must refill from it
      assign w_main_ctrl_d = w_skid_valid ? w_skid_ctrl : i_in.ctrl;
      assign w_main_data_d = w_skid_valid ? w_skid_data : i_in.data;

      always_comb begin
         w_state_nxt = r_state;
         w_main_load = 1'b0;
         w_main_clr  = 1'b0;
         w_skid_load = 1'b0;
         w_skid_clr  = 1'b0;
         if (i_flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_clr  = 1'b1;
            w_skid_clr  = 1'b1;
         end else begin
            case (r_state)
               ST_EMPTY: begin
                  if (w_accept) begin
                     w_state_nxt = ST_ONE;
                     w_main_load = 1'b1;
                  end
               end
               ST_ONE: begin
                  if (w_accept && w_emit) begin
                     w_main_load = 1'b1;
                  end else if (w_accept) begin
                     w_state_nxt = ST_TWO;
                     w_skid_load = 1'b1;
                  end else if (w_emit) begin
                     w_state_nxt = ST_EMPTY;
                     w_main_clr  = 1'b1;
                  end
               end
               ST_TWO: begin
                  if (w_emit) begin
                     w_state_nxt = ST_ONE;
                     w_main_load = 1'b1;
                     w_skid_clr  = 1'b1;
                  end
               end
               default: begin
                  w_state_nxt = ST_EMPTY;
                  w_main_clr  = 1'b1;
                  w_skid_clr  = 1'b1;
               end
            endcase
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
         end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
         end
      end

      // Flush blocks the handshake so no beat is taken and then discarded
      assign w_in_ready  = r_in_ready & ~i_flush;
      assign o_occupancy = r_state;
   end else begin : g_single
      assign w_in_ready    = (o_out.ready | ~w_main_valid) & ~i_flush;
      assign w_main_load   = w_accept;
      assign w_main_clr    = i_flush | (w_emit & ~w_accept);
      assign w_main_ctrl_d = i_in.ctrl;
      assign w_main_data_d = i_in.data;
      assign o_occupancy   = {1'b0, w_main_valid};
   end
endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance, each checked
// against a beat queue that models the stage as an ordered FIFO of depth 1+SKID.
module tb_pipe_stage_reg;
   localparam int unsigned       CW  = 9;
   localparam int unsigned       DW  = 134;
   localparam logic [CW-1:0]     NOP = 9'h006;

   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] data;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          in_valid  [2];
   logic          in_ready  [2];
   logic [CW-1:0] in_ctrl   [2];
   logic [DW-1:0] in_data   [2];
   logic          out_valid [2];
   logic          out_ready [2];
   logic [CW-1:0] out_ctrl  [2];
   logic [DW-1:0] out_data  [2];
   logic          flush     [2];
   logic [1:0]    occ       [2];

   beat_t sb  [2][$];
   beat_t src [2][$];
   bit    gen_v [2];
   bit    ordy  [2];
   bit    fl    [2];
   bit    acc_r [2];
   int    checks = 0;
   int    errors = 0;
   int    seq    = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up_if ();
      pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn_if ();

      assign up_if.valid  = in_valid[g];
      assign up_if.ctrl   = in_ctrl[g];
      assign up_if.data   = in_data[g];
      assign dn_if.ready  = out_ready[g];
      assign in_ready[g]  = up_if.ready;
      assign out_valid[g] = dn_if.valid;
      assign out_ctrl[g]  = dn_if.ctrl;
      assign out_data[g]  = dn_if.data;

      pipe_stage_reg #(
         .CTRL_W   (CW),
         .DATA_W   (DW),
         .CTRL_NOP (NOP),
         .SKID     (g == 1)
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_in        (up_if),
         .o_out       (dn_if),
         .i_flush     (flush[g]),
         .o_occupancy (occ[g])
      );
   end

   task automatic check(input string nm, input int k, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h want %0h", nm, k, act, exp);
      end
   endtask

   // Output monitor: compares against the queue head, then applies this edge's handshakes
   always @(negedge clk) begin : p_mon
      int n;
      bit rdy_exp;
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            sb[k].delete();
            acc_r[k] = 1'b0;
         end else begin
            n       = sb[k].size();
            rdy_exp = !flush[k] && ((k == 1) ? (n < 2) : (out_ready[k] || n == 0));
            check("occupancy", k, occ[k], n);
            check("out_valid", k, out_valid[k], n != 0);
            if (n != 0) check("out_beat", k, {out_ctrl[k], out_data[k]}, sb[k][0]);
            else        check("idle_ctrl", k, out_ctrl[k], NOP);
            check("in_ready", k, in_ready[k], rdy_exp);
            acc_r[k] = in_valid[k] && in_ready[k];
            if (n != 0 && out_ready[k]) void'(sb[k].pop_front());
            if (flush[k]) sb[k].delete();
            if (in_valid[k] && rdy_exp) sb[k].push_back('{ctrl: in_ctrl[k], data: in_data[k]});
         end
      end
   end

   function automatic beat_t mk(input logic [DW-1:0] d);
      beat_t b;
      b.data = d;
      b.ctrl = 9'h1A5 ^ d[8:0];
      return b;
   endfunction

   function automatic beat_t rnd();
      beat_t b;
      b.ctrl = CW'($urandom);
      b.data = {$urandom, $urandom, $urandom, $urandom, 6'(seq)};
      seq++;
      return b;
   endfunction

   // One cycle of stimulus: a beat is held until the previous edge accepted it
   task automatic cyc();
      for (int k = 0; k < 2; k++) begin
         if (!(in_valid[k] && !acc_r[k])) begin
            if (gen_v[k] && src[k].size() != 0) begin
               beat_t b;
               b           = src[k].pop_front();
               in_valid[k] = 1'b1;
               in_ctrl[k]  = b.ctrl;
               in_data[k]  = b.data;
            end else begin
               in_valid[k] = 1'b0;
            end
         end
         out_ready[k] = ordy[k];
         flush[k]     = fl[k];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic push_both(input logic [DW-1:0] d);
      for (int k = 0; k < 2; k++) src[k].push_back(mk(d));
   endtask

   task automatic set_all(input bit v, input bit r, input bit f);
      for (int k = 0; k < 2; k++) begin
         gen_v[k] = v;
         ordy[k]  = r;
         fl[k]    = f;
      end
   endtask

   task automatic reset_checks();
      for (int k = 0; k < 2; k++) begin
         check("rst_out_valid", k, out_valid[k], 1'b0);
         check("rst_out_ctrl",  k, out_ctrl[k],  NOP);
         check("rst_out_data",  k, out_data[k],  '0);
         check("rst_occupancy", k, occ[k],       2'd0);
         check("rst_in_ready",  k, in_ready[k],  1'b1);
      end
   endtask

   task automatic clear_driver();
      for (int k = 0; k < 2; k++) begin
         in_valid[k]  = 1'b0;
         in_ctrl[k]   = '0;
         in_data[k]   = '0;
         out_ready[k] = 1'b0;
         flush[k]     = 1'b0;
         acc_r[k]     = 1'b0;
         src[k].delete();
      end
      set_all(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      clear_driver();
      repeat (2) @(posedge clk);
      #1;
      reset_checks();
      rst_n = 1'b1;

      // Back-to-back streaming
      set_all(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) push_both(DW'(32'h10 + i));
      run(12);

      // Downstream stall while the upstream keeps sending
      for (int i = 0; i < 8; i++) push_both(DW'(32'h10 + i));
      set_all(1'b1, 1'b0, 1'b0);
      run(3);
      set_all(1'b1, 1'b1, 1'b0);
      run(10);

      // Flush with the stage full, then a fresh beat
      push_both(DW'(32'h30));
      push_both(DW'(32'h31));
      set_all(1'b1, 1'b0, 1'b0);
      run(3);
      set_all(1'b1, 1'b0, 1'b1);
      run(1);
      push_both(DW'(32'h20));
      set_all(1'b1, 1'b1, 1'b0);
      run(4);

      // Random traffic, stalls and flushes
      for (int c = 0; c < 10000; c++) begin
         for (int k = 0; k < 2; k++) begin
            gen_v[k] = ($urandom_range(3) != 0);
            ordy[k]  = ($urandom_range(2) != 0);
            fl[k]    = ($urandom_range(31) == 0);
            if (src[k].size() < 2) src[k].push_back(rnd());
         end
         cyc();
      end
      for (int k = 0; k < 2; k++) src[k].delete();
      set_all(1'b0, 1'b1, 1'b0);
      run(5);

      // Asynchronous reset with entries held
      for (int i = 0; i < 3; i++) push_both(DW'(32'h40 + i));
      set_all(1'b1, 1'b0, 1'b0);
      run(3);
      #2;
      rst_n = 1'b0;
      clear_driver();
      #1;
      reset_checks();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) push_both(DW'(32'h50 + i));
      set_all(1'b1, 1'b1, 1'b0);
      run(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
